pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Sequences the 16 MHz PLL wrapper: drives its active-high reset, waits for and qualifies
//  'locked', then releases the downstream system reset. On lock loss or software request it
//  re-locks the PLL; after too many failed attempts it parks in a sticky FAIL state.
//  Runs on the free-running reference clock, never on a PLL output.
// PARAMETERS
//  RST_PULSE_CYCLES    16     cycles pll_rst is held high per attempt (>=1)
//  LOCK_TIMEOUT_CYCLES 16000  WAIT_LOCK cycles before an attempt fails (1 ms @16 MHz)
//  LOCK_STABLE_CYCLES  256    consecutive synced-locked cycles required before RUN
//  MAX_RETRIES         3      retries after the first attempt; total attempts = MAX_RETRIES+1
//  CW                  16     internal timer width; must hold the largest cycle count above
//  RW                  2      retry_cnt width; must hold MAX_RETRIES
// PORTS
//  refclk      in   1   reference clock, free-running
//  rst         in   1   asynchronous, active-low reset
//  pll_locked  in   1   PLL 'locked'; asynchronous, 2-FF synchronised inside to lock_s
//  relock_req  in   1   1-cycle pulse: force a re-lock; acted on only in RUN and FAIL
//  pll_rst     out  1   to PLL reset, active high
//  sys_rst_n   out  1   downstream reset, active low
//  pll_ready   out  1   1 only in RUN
//  pll_fail    out  1   1 only in FAIL
//  retry_cnt   out  RW  failed attempts in the current lock sequence
//  state       out  3   RESET_PLL=0, WAIT_LOCK=1, STABLE_CHK=2, RUN=3, FAIL=4
// BEHAVIOUR
//  - Moore FSM. Outputs decode the registered state and change on the edge that enters a state.
//  - On rst low, immediately and with no clock edge required:
//      state=RESET_PLL, pll_rst=1, sys_rst_n=0, pll_ready=0, pll_fail=0, retry_cnt=0,
//      timer=0, sync flops=0.
//  - RESET_PLL: pll_rst=1, sys_rst_n=0.
//      Leaves after exactly RST_PULSE_CYCLES cycles -> WAIT_LOCK, timer=0.
//  - WAIT_LOCK: pll_rst=0.
//      lock_s=1 -> STABLE_CHK, timer=0.
//      Else, in the cycle timer==LOCK_TIMEOUT_CYCLES-1, the attempt fails:
//        retry_cnt==MAX_RETRIES -> FAIL;
//        otherwise retry_cnt+1 and -> RESET_PLL.
//  - STABLE_CHK: timer counts cycles with lock_s=1.
//      lock_s=0 -> WAIT_LOCK with timer=0 (fresh timeout; retry_cnt unchanged).
//      LOCK_STABLE_CYCLES consecutive locked cycles -> RUN and retry_cnt=0.
//  - RUN: sys_rst_n=1, pll_ready=1.
//      lock_s=0 or relock_req -> RESET_PLL, retry_cnt=0.
//      Both on the same cycle: identical single transition.
//      sys_rst_n falls on that edge, i.e. at most 3 edges after pll_locked falls.
//  - FAIL: pll_fail=1 (sticky), pll_rst=0, sys_rst_n=0.
//      relock_req -> RESET_PLL, retry_cnt=0. Otherwise held until rst.
//  - relock_req is ignored in RESET_PLL, WAIT_LOCK and STABLE_CHK.
//  - Timer saturates and never wraps. Any illegal state encoding -> RESET_PLL.
//  - sys_rst_n is asserted asynchronously by rst and deasserted only synchronously to refclk.
// TESTING (bench params: RST_PULSE=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2)
//  1. Release rst with pll_locked=1 -> pll_rst high for edges 1-4; WAIT_LOCK at edge 4;
//     RUN, sys_rst_n=1, pll_ready=1 at edge 13.
//  2. pll_locked held 0 -> 3 pll_rst pulses of 4 cycles, each followed by 20 WAIT_LOCK cycles;
//     FAIL at edge 72 with pll_fail=1 and retry_cnt=2; stays there for 1000 further cycles.
//  3. Locked, then pll_locked low for 1 cycle at stable count 5 -> returns to WAIT_LOCK,
//     stable count restarts, RUN is entered 8 cycles after re-lock; no pll_rst pulse.
//  4. In RUN, drop pll_locked -> sys_rst_n=0 within 3 edges, a 4-cycle pll_rst pulse,
//     retry_cnt=0, RUN again after lock returns.
//  5. relock_req in FAIL -> RESET_PLL, pll_fail=0, retry_cnt=0.
//     relock_req in WAIT_LOCK -> no state change.
//  6. Assert rst mid-STABLE_CHK between clock edges -> pll_rst=1, sys_rst_n=0 and all other
//     outputs at reset values before the next refclk edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Sequences a PLL wrapper. It pulses the PLL reset, waits for a
//               qualified 'locked', and then releases the downstream reset. On
//               lock loss or a relock request it re-locks. After too many
//               failed attempts it parks in a sticky FAIL state. Runs on the
//               free-running reference clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 16000,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES         = 3,
    parameter int CW                  = 16,
    parameter int RW                  = 2
) (
    input  logic          refclk,
    input  logic          rst,          // asynchronous, active low
    input  logic          pll_locked,
    input  logic          relock_req,
    output logic          pll_rst,
    output logic          sys_rst_n,
    output logic          pll_ready,
    output logic          pll_fail,
    output logic [RW-1:0] retry_cnt,
    output logic [2:0]    state
);

    typedef enum logic [2:0] {
        ST_RESET_PLL  = 3'd0,
        ST_WAIT_LOCK  = 3'd1,
        ST_STABLE_CHK = 3'd2,
        ST_RUN        = 3'd3,
        ST_FAIL       = 3'd4
    } state_t;

    // Terminal timer values: a phase ends in the cycle the timer reaches N-1
    localparam logic [CW-1:0] RST_LAST    = CW'(RST_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TIMER_MAX   = {CW{1'b1}};
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRIES);

    state_t        cur_state;
    state_t        nxt_state;
    logic [CW-1:0] timer;
    logic [CW-1:0] nxt_timer;
    logic [RW-1:0] nxt_retry;
    logic          lock_meta;
    logic          lock_s;

    // Two-flop synchroniser for the asynchronous PLL locked indication
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_s    <= lock_meta;
        end
    end

    // Next-state, timer and retry decisions; the timer saturates by default
    always_comb begin
        nxt_state = cur_state;
        nxt_timer = (timer == TIMER_MAX) ? timer : timer + CW'(1);
        nxt_retry = retry_cnt;
        case (cur_state)
            ST_RESET_PLL: begin
                if (timer >= RST_LAST) begin
                    nxt_state = ST_WAIT_LOCK;
                    nxt_timer = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (lock_s) begin
                    nxt_state = ST_STABLE_CHK;
                    nxt_timer = '0;
                end else if (timer >= TIMEOUT_LAST) begin
                    nxt_timer = '0;
                    if (retry_cnt == RETRY_LIMIT) begin
                        nxt_state = ST_FAIL;
                    end else begin
                        nxt_state = ST_RESET_PLL;
                        nxt_retry = retry_cnt + RW'(1);
                    end
                end
            end
            ST_STABLE_CHK: begin
                if (!lock_s) begin
                    nxt_state = ST_WAIT_LOCK;
                    nxt_timer = '0;
                end else if (timer >= STABLE_LAST) begin
                    nxt_state = ST_RUN;
                    nxt_timer = '0;
                    nxt_retry = '0;
                end
            end
            ST_RUN: begin
                nxt_timer = '0;
                if (!lock_s || relock_req) begin
                    nxt_state = ST_RESET_PLL;
                    nxt_retry = '0;
                end
            end
            ST_FAIL: begin
                nxt_timer = '0;
                if (relock_req) begin
                    nxt_state = ST_RESET_PLL;
                    nxt_retry = '0;
                end
            end
            default: begin
                nxt_state = ST_RESET_PLL;
                nxt_timer = '0;
                nxt_retry = '0;
            end
        endcase
    end

    // State, counters and registered (glitch-free) output decode of the next state
    always_ff @(posedge refclk or negedge rst) begin
        if (!rst) begin
            cur_state <= ST_RESET_PLL;
            timer     <= '0;
            retry_cnt <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            pll_ready <= 1'b0;
            pll_fail  <= 1'b0;
        end else begin
            cur_state <= nxt_state;
            timer     <= nxt_timer;
            retry_cnt <= nxt_retry;
            pll_rst   <= (nxt_state == ST_RESET_PLL);
            sys_rst_n <= (nxt_state == ST_RUN);
            pll_ready <= (nxt_state == ST_RUN);
            pll_fail  <= (nxt_state == ST_FAIL);
        end
    end

    assign state = cur_state;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Self-checking bench for pll_lock_supervisor. A behavioural
//               model predicts all outputs every cycle; directed scenarios pin
//               exact edge timings; a randomized phase exercises the rest.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_supervisor;

    localparam int P_RST = 4;
    localparam int P_TO  = 20;
    localparam int P_ST  = 8;
    localparam int P_MR  = 2;

    logic       refclk = 1'b0;
    logic       rst = 1'b0;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       pll_ready;
    logic       pll_fail;
    logic [1:0] retry_cnt;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (P_RST),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .LOCK_STABLE_CYCLES (P_ST),
        .MAX_RETRIES        (P_MR),
        .CW                 (16),
        .RW                 (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .pll_locked(pll_locked),
        .relock_req(relock_req),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .pll_ready (pll_ready),
        .pll_fail  (pll_fail),
        .retry_cnt (retry_cnt),
        .state     (state)
    );

    always #5 refclk = ~refclk;

    // Behavioural model: mode numbers follow the state codes, m_cnt counts
    // cycles spent in the current phase, lock history models the 2-flop delay.
    int m_mode  = 0;
    int m_cnt   = 0;
    int m_retry = 0;
    bit m_h1    = 1'b0;  // pll_locked seen one edge ago
    bit m_h2    = 1'b0;  // synchronised lock used for decisions
    bit m_ls;

    always @(posedge refclk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_cnt = 0; m_retry = 0; m_h1 = 0; m_h2 = 0;
        end else begin
            m_ls = m_h2;
            case (m_mode)
                0: begin
                    m_cnt++;
                    if (m_cnt == P_RST) begin m_mode = 1; m_cnt = 0; end
                end
                1: begin
                    if (m_ls) begin
                        m_mode = 2; m_cnt = 0;
                    end else begin
                        m_cnt++;
                        if (m_cnt == P_TO) begin
                            m_cnt = 0;
                            if (m_retry == P_MR) m_mode = 4;
                            else begin m_retry++; m_mode = 0; end
                        end
                    end
                end
                2: begin
                    if (!m_ls) begin
                        m_mode = 1; m_cnt = 0;
                    end else begin
                        m_cnt++;
                        if (m_cnt == P_ST) begin m_mode = 3; m_cnt = 0; m_retry = 0; end
                    end
                end
                3: if (!m_ls || relock_req) begin m_mode = 0; m_cnt = 0; m_retry = 0; end
                4: if (relock_req) begin m_mode = 0; m_cnt = 0; m_retry = 0; end
                default: m_mode = 0;
            endcase
            m_h2 = m_h1;
            m_h1 = pll_locked;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {state, pll_rst, sys_rst_n, pll_ready, pll_fail, retry_cnt};
    endfunction

    // Per-cycle comparison of every output against the model
    always @(negedge refclk) begin
        if (rst === 1'b1) begin
            chk("model_cycle", 32'(dut_vec()),
                32'({3'(m_mode), m_mode == 0, m_mode == 3, m_mode == 3, m_mode == 4, 2'(m_retry)}));
        end
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic wait_state(input int st, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            tick();
            if (state == 3'(st)) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_state: actual state=%0d required=%0d within %0d cycles", state, st, max_cycles);
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
    endtask

    initial begin
        // Test 1: release rst with lock present
        pll_locked = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 3)  chk("t1_rst_e3", {29'd0, state, pll_rst}, {29'd0, 3'd0, 1'b1});
            if (e == 4)  chk("t1_wait_e4", {29'd0, state, pll_rst}, {29'd0, 3'd1, 1'b0});
            if (e == 12) chk("t1_stable_e12", {29'd0, state, sys_rst_n}, {29'd0, 3'd2, 1'b0});
            if (e == 13) chk("t1_run_e13", {28'd0, state, sys_rst_n, pll_ready},
                             {28'd0, 3'd3, 1'b1, 1'b1});
        end

        // Test 4: lock loss in RUN
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        chk("t4_sys_e1", 32'(sys_rst_n), 32'd1);
        tick();
        chk("t4_sys_e2", 32'(sys_rst_n), 32'd1);
        tick();
        chk("t4_drop_e3", {27'd0, state, pll_rst, sys_rst_n, retry_cnt == 2'd0},
            {27'd0, 3'd0, 1'b1, 1'b0, 1'b1});
        tick();
        pll_locked = 1'b1;
        wait_state(3, 200);
        chk("t4_rerun_retry", 32'(retry_cnt), 32'd0);

        // Test 3: one-cycle lock glitch at stable count 5
        pulse_relock();
        wait_state(2, 200);
        repeat (3) tick();
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        tick();
        tick();
        chk("t3_back_wait", {29'd0, state, pll_rst}, {29'd0, 3'd1, 1'b0});
        tick();
        chk("t3_restable", {29'd0, state, pll_rst}, {29'd0, 3'd2, 1'b0});
        repeat (7) tick();
        chk("t3_stable_minus1", 32'(state), 32'd2);
        tick();
        chk("t3_run_8_after", 32'(state), 32'd3);

        // Test 6: asynchronous reset between edges during STABLE_CHK
        pulse_relock();
        wait_state(2, 200);
        tick();
        #3;
        rst = 1'b0;
        #1;
        chk("t6_async_rst", 32'(dut_vec()), 32'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0}));
        tick();

        // Test 2: never locks -> FAIL after three attempts
        pll_locked = 1'b0;
        rst = 1'b1;
        for (int e = 1; e <= 72; e++) begin
            tick();
            if (e == 24) chk("t2_retry1_e24", {29'd0, state, retry_cnt}, {29'd0, 3'd0, 2'd1});
            if (e == 71) chk("t2_wait_e71", 32'(state), 32'd1);
            if (e == 72) chk("t2_fail_e72", {26'd0, state, pll_fail, pll_rst, sys_rst_n, retry_cnt},
                             {26'd0, 3'd4, 1'b1, 1'b0, 1'b0, 2'd2});
        end
        repeat (1000) tick();
        chk("t2_sticky", {28'd0, state, pll_fail}, {28'd0, 3'd4, 1'b1});

        // Test 5: relock from FAIL, then relock ignored in WAIT_LOCK
        pulse_relock();
        chk("t5_fail_relock", {26'd0, state, pll_fail, retry_cnt}, {26'd0, 3'd0, 1'b0, 2'd0});
        repeat (5) tick();
        chk("t5_in_wait", 32'(state), 32'd1);
        pulse_relock();
        chk("t5_wait_ignore", 32'(state), 32'd1);

        // Randomized phase: lock segments of random level/length, sparse relock pulses
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            len = int'($urandom_range(1, 60));
            pll_locked = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < len; c++) begin
                relock_req = ($urandom_range(0, 39) == 0);
                tick();
            end
            relock_req = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
